light_bar_overlay: RTL and testbench
====================================

LIGHT_BAR_OVERLAY -- requirements
Module: light_bar_overlay

Interface
REQ-001 Parameter N_BOX, default 5, meaning number of boxes in the bar, range 1..16.
REQ-002 Parameter X0, default 464, meaning left pixel column of box 0.
REQ-003 Parameter Y0, default 279, meaning top pixel row of all boxes.
REQ-004 Parameter BOX_W, default 21, meaning outer box width in pixels.
REQ-005 Parameter BOX_H, default 13, meaning outer box height in pixels.
REQ-006 Parameter GAP, default 1, meaning number of blank columns between adjacent boxes.
REQ-007 Parameter BORDER, default 2, meaning border thickness in pixels.
REQ-008 Parameter FRAMES_PER_STEP, default 32, meaning frames per animation step, minimum 1.
REQ-009 Port clk, input, 1 bit, is the single clock.
REQ-010 Port reset, input, 1 bit, is an asynchronous active-low reset; 0 means in reset.
REQ-011 Port pix_x, input, 10 bits, is the current pixel column.
REQ-012 Port pix_y, input, 10 bits, is the current pixel row.
REQ-013 Port video_on, input, 1 bit, means the current pixel is in the visible area.
REQ-014 Port enable, input, 1 bit, means animation advance is allowed.
REQ-015 Port mode, input, 2 bits, selects the animation: 0 FILL, 1 CHASE, 2 BOUNCE, 3 HOLD.
REQ-016 Port color, input, 12 bits, is the RGB444 colour of a lit interior.
REQ-017 Port rgbtext, output, 12 bits, is the registered pixel colour.
REQ-018 Port overlay_on, output, 1 bit, is registered and is 1 when the pixel lies in any box.
REQ-019 Port step_pulse, output, 1 bit, is a one-cycle pulse on each position update.

Function
REQ-020 Box k SHALL span x from X0+k*(BOX_W+GAP) to that value plus BOX_W-1, and y from Y0 to Y0+BOX_H-1.
REQ-021 A pixel in box k within BORDER of any box edge SHALL be a border pixel; every other pixel in box k SHALL be an interior pixel.
REQ-022 Pixel colour SHALL be: 0 when video_on=0 or the pixel is outside all boxes; color for a lit interior; 12'h000 for an unlit interior; 12'hFFF for a border.
REQ-023 rgbtext and overlay_on SHALL reflect the inputs sampled one clk earlier (latency 1).
REQ-024 The frame tick SHALL be the rising edge of the condition (pix_x==0 && pix_y==0): exactly one tick per frame, however many cycles the condition holds.
REQ-025 The frame counter SHALL count frame ticks only while enable=1; on reaching FRAMES_PER_STEP-1 it SHALL wrap to 0, update pos, and assert step_pulse for one cycle.
REQ-026 FILL mode: pos SHALL advance 0..N_BOX and then wrap to 0; box i is lit when i<pos.
REQ-027 CHASE mode: pos SHALL advance 0..N_BOX-1 and then wrap to 0; box i is lit when i==pos.
REQ-028 BOUNCE mode: pos SHALL move in direction dir; dir SHALL flip on reaching N_BOX-1 or 0; box i is lit when i==pos; with N_BOX=1, pos SHALL stay 0.
REQ-029 HOLD mode: pos SHALL be frozen and the FILL lit rule SHALL apply; step_pulse SHALL still fire.
REQ-030 A change in mode SHALL, on the next cycle, clear pos, frame counter and the frame-edge register and set dir=up; this takes priority over a simultaneous step.
REQ-031 While enable=0, pos and the frame counter SHALL hold, drawing SHALL continue, and step_pulse SHALL be 0.
REQ-032 Elaboration SHALL fail if X0+N_BOX*(BOX_W+GAP) > 1024, if 2*BORDER >= min(BOX_W,BOX_H), or if FRAMES_PER_STEP < 1.

Reset
REQ-033 While reset=0, the block SHALL immediately force rgbtext=0, overlay_on=0, step_pulse=0, pos=0, dir=up, frame counter=0 and frame-edge register=0, with no clock edge required.
REQ-034 After reset is released, the first frame tick SHALL count as frame 1 of the first step.

Structure
REQ-035 Package light_bar_pkg SHALL hold the mode encodings (MODE_FILL, MODE_CHASE, MODE_BOUNCE, MODE_HOLD) and the colour constants (COLOR_WHITE=12'hFFF, COLOR_BLACK=12'h000).
REQ-036 Sub-module light_bar_seq SHALL contain the frame-edge detect, frame counter, pos/dir state machine and step_pulse; the box geometry and colour mux SHALL stay in the top level as a generate loop over N_BOX.

Verification (default parameters, color=12'hF80)
REQ-037 Reset then pixel (464,285) followed by pixel (470,285), video_on=1 -> rgbtext 12'hFFF then 12'h000; pixel (485,285) -> 12'h000 with overlay_on=0.
REQ-038 FILL for 32 frames -> pos=1 and (470,285) gives 12'hF80; after 160 frames all 5 interiors are lit; after 192 frames pos=0.
REQ-039 BOUNCE over 10 steps -> pos sequence 0,1,2,3,4,3,2,1,0,1, with step_pulse exactly once every 32 frames.
REQ-040 pix_x=pix_y=0 held for 4 cycles -> counts as one frame; enable=0 for 100 frames -> pos unchanged and no step_pulse.
REQ-041 Change mode from BOUNCE to CHASE at pos=3 -> pos=0 on the next cycle; reset asserted asynchronously between clock edges -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/light_bar_pkg.sv
// Shared encodings and helpers for the light-bar overlay: animation modes,
// fixed colours and the geometry helper used by the box generate loop.
package light_bar_pkg;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    localparam logic [11:0] COLOR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOR_BLACK = 12'h000;

    // Wide enough for pos values 0..16 (FILL needs one value past the last box).
    localparam int POS_W = 5;

    function automatic logic [10:0] box_left(input int x0, input int k,
                                             input int w, input int gap);
        return 11'(x0 + k * (w + gap));
    endfunction

endpackage

// File: rtl/light_bar_overlay_if.sv
// Pixel stream into the overlay and the registered pixel result back out.
interface light_bar_overlay_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        video_on;
    logic [11:0] rgbtext;
    logic        overlay_on;

    modport master (output pix_x, pix_y, video_on, input rgbtext, overlay_on);
    modport slave  (input pix_x, pix_y, video_on, output rgbtext, overlay_on);
endinterface

// File: rtl/light_bar_seq.sv
// Frame-edge detect, frame counter and pos/dir animation state; produces the
// per-box lit mask and a one-cycle pulse on every step.
module light_bar_seq
    import light_bar_pkg::*;
#(
    parameter int N_BOX           = 5,
    parameter int FRAMES_PER_STEP = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [N_BOX-1:0] lit,
    output logic             step_pulse
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_BOX - 1);
    localparam logic [POS_W-1:0] POS_FULL = POS_W'(N_BOX);
    localparam bit               CAN_BOUNCE = (N_BOX > 1);

    logic             edge_reg,  edge_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [POS_W-1:0] pos_reg,   pos_next;
    logic             dir_reg,   dir_next;
    mode_e            mode_reg,  mode_next;
    logic             step_reg,  step_next;

    logic             frame_cond, tick, step, mode_chg;
    logic [POS_W-1:0] pos_bounce;
    mode_e            mode_cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_reg <= 1'b0;
            cnt_reg  <= '0;
            pos_reg  <= '0;
            dir_reg  <= 1'b1;
            mode_reg <= MODE_FILL;
            step_reg <= 1'b0;
        end else begin
            edge_reg <= edge_next;
            cnt_reg  <= cnt_next;
            pos_reg  <= pos_next;
            dir_reg  <= dir_next;
            mode_reg <= mode_next;
            step_reg <= step_next;
        end
    end

    always_comb begin
        mode_cur   = mode_e'(mode);
        frame_cond = (pix_x == 10'd0) && (pix_y == 10'd0);
        mode_chg   = (mode_cur != mode_reg);
        tick       = frame_cond && !edge_reg && enable;
        step       = tick && (cnt_reg == CNT_LAST);
        pos_bounce = dir_reg ? pos_reg + POS_W'(1) : pos_reg - POS_W'(1);

        edge_next = frame_cond;
        cnt_next  = cnt_reg;
        pos_next  = pos_reg;
        dir_next  = dir_reg;
        mode_next = mode_cur;
        step_next = 1'b0;

        // A mode change restarts the animation and swallows any coincident step.
        if (mode_chg) begin
            edge_next = 1'b0;
            cnt_next  = '0;
            pos_next  = '0;
            dir_next  = 1'b1;
        end else if (tick) begin
            cnt_next = step ? '0 : cnt_reg + CNT_W'(1);
            if (step) begin
                step_next = 1'b1;
                case (mode_reg)
                    MODE_FILL:   pos_next = (pos_reg == POS_FULL) ? '0 : pos_reg + POS_W'(1);
                    MODE_CHASE:  pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
                    MODE_BOUNCE: begin
                        if (CAN_BOUNCE) begin
                            pos_next = pos_bounce;
                            if (pos_bounce == POS_LAST || pos_bounce == '0)
                                dir_next = ~dir_reg;
                        end
                    end
                    default:     pos_next = pos_reg;
                endcase
            end
        end
    end

    always_comb begin
        lit = '0;
        for (int i = 0; i < N_BOX; i++) begin
            if (mode_reg == MODE_FILL || mode_reg == MODE_HOLD)
                lit[i] = (POS_W'(i) < pos_reg);
            else
                lit[i] = (POS_W'(i) == pos_reg);
        end
        step_pulse = step_reg;
    end

endmodule

// File: rtl/light_bar_overlay.sv
// Row of bordered boxes drawn over the video stream, interiors lit according
// to the animation state from light_bar_seq; output registered (latency 1).
module light_bar_overlay
    import light_bar_pkg::*;
#(
    parameter int N_BOX           = 5,
    parameter int X0              = 464,
    parameter int Y0              = 279,
    parameter int BOX_W           = 21,
    parameter int BOX_H           = 13,
    parameter int GAP             = 1,
    parameter int BORDER          = 2,
    parameter int FRAMES_PER_STEP = 32
) (
    input  logic                clk,
    input  logic                reset,
    light_bar_overlay_if.slave  pix,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [11:0]         color,
    output logic                step_pulse
);

    localparam int MIN_SIDE = (BOX_W < BOX_H) ? BOX_W : BOX_H;

    if (N_BOX < 1 || N_BOX > 16) begin : g_bad_nbox
        $fatal(1, "light_bar_overlay: N_BOX out of range 1..16");
    end
    if (X0 + N_BOX * (BOX_W + GAP) > 1024) begin : g_bad_width
        $fatal(1, "light_bar_overlay: bar extends past column 1023");
    end
    if (2 * BORDER >= MIN_SIDE) begin : g_bad_border
        $fatal(1, "light_bar_overlay: border leaves no interior");
    end
    if (FRAMES_PER_STEP < 1) begin : g_bad_fps
        $fatal(1, "light_bar_overlay: FRAMES_PER_STEP must be at least 1");
    end

    logic [N_BOX-1:0] lit, in_box, is_border;
    logic [11:0]      box_rgb [N_BOX];
    logic [11:0]      pix_rgb;
    logic [10:0]      px, py;
    logic [11:0]      rgb_reg;
    logic             overlay_reg;

    light_bar_seq #(
        .N_BOX           (N_BOX),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .pix_x      (pix.pix_x),
        .pix_y      (pix.pix_y),
        .enable     (enable),
        .mode       (mode),
        .lit        (lit),
        .step_pulse (step_pulse)
    );

    assign px = {1'b0, pix.pix_x};
    assign py = {1'b0, pix.pix_y};

    for (genvar gi = 0; gi < N_BOX; gi++) begin : g_box
        localparam logic [10:0] XL = box_left(X0, gi, BOX_W, GAP);
        localparam logic [10:0] XR = XL + 11'(BOX_W - 1);
        localparam logic [10:0] YT = 11'(Y0);
        localparam logic [10:0] YB = 11'(Y0 + BOX_H - 1);
        localparam logic [10:0] BI = 11'(BORDER);

        assign in_box[gi]    = (px >= XL) && (px <= XR) && (py >= YT) && (py <= YB);
        assign is_border[gi] = (px < XL + BI) || (px > XR - BI) ||
                               (py < YT + BI) || (py > YB - BI);
        assign box_rgb[gi]   = !in_box[gi]   ? 12'h000     :
                               is_border[gi] ? COLOR_WHITE :
                               lit[gi]       ? color       : COLOR_BLACK;
    end

    // Boxes never overlap, so at most one term below is non-zero.
    always_comb begin
        pix_rgb = 12'h000;
        for (int k = 0; k < N_BOX; k++)
            pix_rgb = pix_rgb | box_rgb[k];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_reg     <= 12'h000;
            overlay_reg <= 1'b0;
        end else begin
            rgb_reg     <= pix.video_on ? pix_rgb : 12'h000;
            overlay_reg <= |in_box;
        end
    end

    assign pix.rgbtext    = rgb_reg;
    assign pix.overlay_on = overlay_reg;

endmodule

// File: tb/tb_light_bar_overlay.sv
// Directed plus randomized bench for light_bar_overlay with a reference model
// that derives pos from the count of enabled frames since the last restart.
module tb_light_bar_overlay;

    localparam int N      = 5;
    localparam int X0     = 464;
    localparam int Y0     = 279;
    localparam int BW     = 21;
    localparam int BH     = 13;
    localparam int PITCH  = 22;
    localparam int BRD    = 2;
    localparam int FPS    = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] color;
    logic        step_pulse;

    int checks   = 0;
    int failures = 0;

    // Model state: current mode and enabled frame ticks since reset/mode change.
    int m_mode;
    int m_frames;

    light_bar_overlay_if bus();

    light_bar_overlay dut (
        .clk        (clk),
        .reset      (reset),
        .pix        (bus),
        .enable     (enable),
        .mode       (mode),
        .color      (color),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    function automatic int model_pos();
        int steps;
        int p;
        steps = m_frames / FPS;
        case (m_mode)
            0: return steps % (N + 1);
            1: return steps % N;
            2: begin
                p = steps % (2 * (N - 1));
                return (p <= N - 1) ? p : 2 * (N - 1) - p;
            end
            default: return 0;
        endcase
    endfunction

    function automatic bit model_lit(int k);
        if (m_mode == 0 || m_mode == 3) return k < model_pos();
        return k == model_pos();
    endfunction

    function automatic int box_of(int x, int y);
        int rel;
        int dy;
        rel = x - X0;
        dy  = y - Y0;
        if (rel < 0 || dy < 0 || dy >= BH) return -1;
        if (rel / PITCH >= N || rel % PITCH >= BW) return -1;
        return rel / PITCH;
    endfunction

    function automatic logic [11:0] exp_rgb(int x, int y, bit v);
        int k;
        int off;
        int dy;
        k = box_of(x, y);
        if (!v || k < 0) return 12'h000;
        off = (x - X0) % PITCH;
        dy  = y - Y0;
        if (off < BRD || off >= BW - BRD || dy < BRD || dy >= BH - BRD) return 12'hFFF;
        return model_lit(k) ? color : 12'h000;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic px_check(input int x, input int y, input bit v, input string tag);
        logic [11:0] e_rgb;
        logic [11:0] e_ovl;
        bus.pix_x    = 10'(x);
        bus.pix_y    = 10'(y);
        bus.video_on = v;
        e_rgb = exp_rgb(x, y, v);
        e_ovl = (box_of(x, y) >= 0) ? 12'd1 : 12'd0;
        cyc();
        chk({tag, "_rgb"}, bus.rgbtext, e_rgb);
        chk({tag, "_ovl"}, {11'd0, bus.overlay_on}, e_ovl);
    endtask

    task automatic check_boxes(input string tag);
        for (int k = 0; k < N; k++)
            px_check(X0 + k * PITCH + 10, 285, 1'b1, tag);
    endtask

    // One frame: hold (0,0) for 'hold' cycles, then move off the origin.
    task automatic frame(input int hold);
        int pulses;
        int e_pulse;
        pulses = 0;
        bus.video_on = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.pix_x = 10'd0;
            bus.pix_y = 10'd0;
            cyc();
            pulses += int'(step_pulse);
        end
        bus.pix_x = 10'd5;
        bus.pix_y = 10'd5;
        cyc();
        pulses += int'(step_pulse);
        e_pulse = 0;
        if (enable) begin
            m_frames++;
            if (m_frames % FPS == 0) e_pulse = 1;
        end
        chk("step_pulse", 12'(pulses), 12'(e_pulse));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1);
    endtask

    task automatic set_mode(input int new_mode);
        mode      = 2'(new_mode);
        bus.pix_x = 10'd5;
        bus.pix_y = 10'd5;
        cyc();
        if (new_mode != m_mode) begin
            m_mode   = new_mode;
            m_frames = 0;
        end
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        mode         = 2'd0;
        color        = 12'hF80;
        bus.pix_x    = 10'd464;
        bus.pix_y    = 10'd279;
        bus.video_on = 1'b1;
        m_mode       = 0;
        m_frames     = 0;
        repeat (3) cyc();
        chk("reset_rgb", bus.rgbtext, 12'h000);
        chk("reset_ovl", {11'd0, bus.overlay_on}, 12'd0);
        chk("reset_step", {11'd0, step_pulse}, 12'd0);
        bus.pix_x = 10'd5;
        bus.pix_y = 10'd5;
        reset     = 1'b1;
        cyc();

        px_check(464, 285, 1'b1, "border");
        px_check(470, 285, 1'b1, "unlit");
        px_check(485, 285, 1'b1, "gap");
        px_check(470, 285, 1'b0, "video_off");

        // FILL: first frame holds the origin for 4 cycles and must count once.
        frame(4);
        frames(31);
        px_check(470, 285, 1'b1, "fill_step1");
        check_boxes("fill32");
        frames(128);
        check_boxes("fill160");
        frames(32);
        check_boxes("fill192");

        frames(40);
        enable = 1'b0;
        frames(100);
        check_boxes("disabled");
        enable = 1'b1;

        set_mode(2);
        for (int s = 1; s <= 11; s++) begin
            frames(FPS);
            check_boxes("bounce");
        end
        set_mode(1);
        check_boxes("chase_after_bounce");

        for (int seg = 0; seg < 6; seg++) begin
            set_mode(int'($urandom_range(0, 3)));
            enable = ($urandom_range(0, 3) != 0);
            frames(int'($urandom_range(1, 70)));
            check_boxes("rand_boxes");
            for (int p = 0; p < 8; p++)
                px_check(int'($urandom_range(440, 600)), int'($urandom_range(270, 300)),
                         1'($urandom_range(0, 1)), "rand_pix");
        end
        enable = 1'b1;

        // Asynchronous reset between edges must clear outputs immediately.
        px_check(464, 285, 1'b1, "pre_reset");
        #3;
        reset = 1'b0;
        #1;
        chk("async_rgb", bus.rgbtext, 12'h000);
        chk("async_ovl", {11'd0, bus.overlay_on}, 12'd0);
        chk("async_step", {11'd0, step_pulse}, 12'd0);
        mode = 2'd0;
        bus.pix_x = 10'd5;
        bus.pix_y = 10'd5;
        cyc();
        reset    = 1'b1;
        m_mode   = 0;
        m_frames = 0;
        cyc();
        frames(FPS);
        check_boxes("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
